// File: rtl/masku_operand_queue_pkg.sv
// Shared types for the mask-unit operand queue: element type, slot count and FSM encoding.
package masku_operand_queue_pkg;

  localparam int ELEN = 64;
  localparam int NrMaskFUnits = 2;
  // v0.m, vs1, vs2 plus one result slot per mask functional unit
  localparam int NrMaskuOpSlots = NrMaskFUnits + 3;

  typedef logic [ELEN-1:0] elen_t;

  typedef enum logic {MASKU_OQ_IDLE, MASKU_OQ_RUN} masku_oq_state_e;

endpackage

// File: rtl/masku_oq_fifo.sv
// Small per-lane/per-slot operand FIFO. Head is read from registers, so data pushed
// in one cycle is visible the next; there is no fall-through path.
module masku_oq_fifo
  import masku_operand_queue_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  flush_i,
  input  logic  push_i,
  input  elen_t data_i,
  input  logic  pop_i,
  output elen_t data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntWidth = $clog2(Depth + 1);

  elen_t                mem_reg [Depth];
  logic  [PtrWidth-1:0] wr_ptr_reg, rd_ptr_reg;
  logic  [CntWidth-1:0] cnt_reg;
  logic                 push_ok, pop_ok;

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_reg == CntWidth'(Depth));
  assign empty_o = (cnt_reg == '0);
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;
  assign data_o  = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else if (flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (pop_ok)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({push_ok, pop_ok})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  // Storage needs no reset: an empty FIFO's head is never exposed downstream.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= data_i;
  end

endmodule

// File: rtl/masku_operand_queue.sv
// Aligns skewed per-lane operands into full beats for the mask unit, counts beats
// per instruction and pulses done_o one cycle after the last beat.
module masku_operand_queue
  import masku_operand_queue_pkg::*;
#(
  parameter int NrLanes      = 0,
  parameter int Depth        = 2,
  parameter int BeatCntWidth = 16
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          flush_i,
  input  elen_t [NrLanes-1:0][NrMaskuOpSlots-1:0]       masku_operand_i,
  input  logic  [NrLanes-1:0][NrMaskuOpSlots-1:0]       masku_operand_valid_i,
  output logic  [NrLanes-1:0][NrMaskuOpSlots-1:0]       masku_operand_ready_o,
  input  logic                                          start_i,
  input  logic  [BeatCntWidth-1:0]                      nr_beats_i,
  input  logic  [NrMaskuOpSlots-1:0]                    req_slots_i,
  output elen_t [NrLanes-1:0][NrMaskuOpSlots-1:0]       beat_o,
  output logic                                          beat_valid_o,
  input  logic                                          beat_ready_i,
  output logic                                          busy_o,
  output logic                                          done_o
);

  masku_oq_state_e               state_reg, state_next;
  logic [BeatCntWidth-1:0]       cnt_reg, cnt_next;
  logic [NrMaskuOpSlots-1:0]     req_slots_reg, req_slots_next;
  logic                          done_reg, done_next;

  logic  [NrLanes-1:0][NrMaskuOpSlots-1:0] fifo_full, fifo_empty, slot_ok;
  elen_t [NrLanes-1:0][NrMaskuOpSlots-1:0] fifo_head;
  logic                                    handshake;

  assign handshake = beat_valid_o && beat_ready_i && !flush_i;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NrLanes; gi++) begin : g_lane
      for (gj = 0; gj < NrMaskuOpSlots; gj++) begin : g_slot
        masku_oq_fifo #(.Depth(Depth)) i_fifo (
          .clk_i   (clk_i),
          .rst_i   (rst_i),
          .flush_i (flush_i),
          .push_i  (masku_operand_valid_i[gi][gj]),
          .data_i  (masku_operand_i[gi][gj]),
          .pop_i   (handshake && req_slots_reg[gj]),
          .data_o  (fifo_head[gi][gj]),
          .full_o  (fifo_full[gi][gj]),
          .empty_o (fifo_empty[gi][gj])
        );
        assign masku_operand_ready_o[gi][gj] = !fifo_full[gi][gj];
        assign slot_ok[gi][gj] = !req_slots_reg[gj] || !fifo_empty[gi][gj];
        assign beat_o[gi][gj]  = (beat_valid_o && req_slots_reg[gj]) ? fifo_head[gi][gj] : '0;
      end
    end
  endgenerate

  assign beat_valid_o = (state_reg == MASKU_OQ_RUN) && (&slot_ok);
  assign busy_o       = (state_reg == MASKU_OQ_RUN);
  assign done_o       = done_reg;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    req_slots_next = req_slots_reg;
    done_next      = 1'b0;
    if (flush_i) begin
      state_next     = MASKU_OQ_IDLE;
      cnt_next       = '0;
      req_slots_next = '0;
    end else begin
      case (state_reg)
        MASKU_OQ_IDLE: begin
          if (start_i) begin
            // A zero-beat instruction completes without ever entering RUN
            if (nr_beats_i != '0) begin
              state_next     = MASKU_OQ_RUN;
              cnt_next       = nr_beats_i;
              req_slots_next = req_slots_i;
            end else begin
              done_next = 1'b1;
            end
          end
        end
        MASKU_OQ_RUN: begin
          if (handshake) begin
            cnt_next = cnt_reg - 1'b1;
            if (cnt_reg == BeatCntWidth'(1)) begin
              state_next = MASKU_OQ_IDLE;
              done_next  = 1'b1;
            end
          end
        end
        default: state_next = MASKU_OQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= MASKU_OQ_IDLE;
      cnt_reg       <= '0;
      req_slots_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      req_slots_reg <= req_slots_next;
      done_reg      <= done_next;
    end
  end

endmodule
